// File: rtl/muldiv_pkg.sv
// Shared definitions for the EXM1 multiply/divide controller: op encodings,
// FSM states, iteration count and divide-by-zero result constants.
package muldiv_pkg;

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned CNT_W    = 5;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  // Divide by zero: quotient saturates to all ones, remainder is the dividend.
  localparam logic [MD_XLEN-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } md_state_e;

  function automatic logic [MD_XLEN-1:0] cond_neg(input logic [MD_XLEN-1:0] v,
                                                  input logic            neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EXM1 pipeline (master) and muldiv_ctrl (slave).
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            AnyStall;
  logic            MdValid_ID;
  logic [2:0]      MdOp_ID;
  logic [XLEN-1:0] SrcA_ID;
  logic [XLEN-1:0] SrcB_ID;
  logic            MdStall_EXM1;
  logic [XLEN-1:0] MdResult_EXM1;
  logic            MdBusy;
  logic [XLEN-1:0] Hi_MD;
  logic [XLEN-1:0] Lo_MD;

  modport master (
    output flush, AnyStall, MdValid_ID, MdOp_ID, SrcA_ID, SrcB_ID,
    input  MdStall_EXM1, MdResult_EXM1, MdBusy, Hi_MD, Lo_MD
  );

  modport slave (
    input  flush, AnyStall, MdValid_ID, MdOp_ID, SrcA_ID, SrcB_ID,
    output MdStall_EXM1, MdResult_EXM1, MdBusy, Hi_MD, Lo_MD
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {acc, opr}: shift-add for multiply (multiplier
// drains from opr[0]), restoring shift-subtract for divide (quotient fills opr[0]).
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] opr_i,
  input  logic [XLEN-1:0] dsr_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] opr_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i} + {1'b0, ({XLEN{opr_i[0]}} & dsr_i)};
    rem_sh = {acc_i, opr_i[XLEN-1]};
    // Only used when rem_sh >= divisor, so the result always fits XLEN bits.
    diff   = rem_sh[XLEN-1:0] - dsr_i;
    acc_o  = sum[XLEN:1];
    opr_o  = {sum[0], opr_i[XLEN-1:1]};
    if (is_div_i) begin
      if (rem_sh >= {1'b0, dsr_i}) begin
        acc_o = diff;
        opr_o = {opr_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = rem_sh[XLEN-1:0];
        opr_o = {opr_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for the iterative mul/div engine beside EXM1.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes once remaining multiplier bits are zero.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = XLEN
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);

  localparam int unsigned W2 = 2 * XLEN;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  acc_q, opr_q, dsr_q, hi_q, lo_q;
  logic             div_q, qneg_q, rneg_q, dz_q;

  logic             busy_c, accept_c, sgn_op_c, neg_a_c, neg_b_c;
  logic [XLEN-1:0]  mag_a_c, mag_b_c, step_acc_c, step_opr_c;
  logic [XLEN-1:0]  hi_d, lo_d;
  logic [W2-1:0]    prod_d, aligned_d;
  logic             mul_done_d;

  assign busy_c   = (state_q != ST_IDLE);
  assign accept_c = bus.MdValid_ID & ~bus.flush & ~bus.AnyStall & ~busy_c;
  assign sgn_op_c = ~bus.MdOp_ID[2] & ~bus.MdOp_ID[0];
  assign neg_a_c  = sgn_op_c & bus.SrcA_ID[XLEN-1];
  assign neg_b_c  = sgn_op_c & bus.SrcB_ID[XLEN-1];
  assign mag_a_c  = cond_neg(bus.SrcA_ID, neg_a_c);
  assign mag_b_c  = cond_neg(bus.SrcB_ID, neg_b_c);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (div_q),
    .acc_i    (acc_q),
    .opr_i    (opr_q),
    .dsr_i    (dsr_q),
    .acc_o    (step_acc_c),
    .opr_o    (step_opr_c)
  );

  // Multiply completion and product alignment; cnt_q is the shifts still owed.
  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    mul_done_d = (cnt_q == '0) ||
                 ((step_opr_c & ~({XLEN{1'b1}} << cnt_q)) == '0);
    aligned_d  = {step_acc_c, step_opr_c} >> cnt_q;
`else
    mul_done_d = (cnt_q == '0);
    aligned_d  = {step_acc_c, step_opr_c};
`endif
  end

  // Sign correction applied in FIXUP.
  always_comb begin
    prod_d = qneg_q ? -{acc_q, opr_q} : {acc_q, opr_q};
    hi_d   = prod_d[W2-1:XLEN];
    lo_d   = prod_d[XLEN-1:0];
    if (div_q) begin
      hi_d = cond_neg(acc_q, rneg_q);
      lo_d = dz_q ? DIV0_QUOT : cond_neg(opr_q, qneg_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opr_q   <= '0;
      dsr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (bus.MdOp_ID == OP_MTHI) begin
              hi_q <= bus.SrcA_ID;
            end else if (bus.MdOp_ID == OP_MTLO) begin
              lo_q <= bus.SrcA_ID;
            end else if (!bus.MdOp_ID[2]) begin
              state_q <= bus.MdOp_ID[1] ? ST_DIV : ST_MUL;
              cnt_q   <= CNT_W'(ITERS - 1);
              div_q   <= bus.MdOp_ID[1];
              acc_q   <= '0;
              qneg_q  <= neg_a_c ^ neg_b_c;
              rneg_q  <= bus.MdOp_ID[1] & neg_a_c;
              dz_q    <= bus.MdOp_ID[1] & (bus.SrcB_ID == '0);
              // Divide shifts the dividend out of opr; multiply drains the multiplier.
              opr_q   <= bus.MdOp_ID[1] ? mag_a_c : mag_b_c;
              dsr_q   <= bus.MdOp_ID[1] ? mag_b_c : mag_a_c;
            end
          end
        end
        ST_MUL: begin
          {acc_q, opr_q} <= aligned_d;
          cnt_q          <= cnt_q - CNT_W'(1);
          if (mul_done_d) state_q <= ST_FIXUP;
        end
        ST_DIV: begin
          acc_q <= step_acc_c;
          opr_q <= step_opr_c;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= ST_FIXUP;
        end
        ST_FIXUP: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.MdResult_EXM1 = '0;
    if (accept_c && bus.MdOp_ID == OP_MFHI) bus.MdResult_EXM1 = hi_q;
    else if (accept_c && bus.MdOp_ID == OP_MFLO) bus.MdResult_EXM1 = lo_q;
  end

  assign bus.MdStall_EXM1 = bus.MdValid_ID & ~bus.flush & busy_c;
  assign bus.MdBusy       = busy_c;
  assign bus.Hi_MD        = hi_q;
  assign bus.Lo_MD        = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl against a plain-arithmetic HI/LO/latency model.
module tb_muldiv_ctrl;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_ctrl #(.XLEN(XLEN), .ITERS(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: HI/LO from 64-bit arithmetic, busy-cycle count from op class.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] m;
    int          k;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      3'b000: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'b001: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'b010: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; p = 64'(q); lo = p[31:0]; p = 64'(r); hi = p[31:0]; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
    endcase
    lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      m = (op == 3'b000 && b[31]) ? -b : b;
      k = 0;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      if (k == 0) k = 1;
      lat = k + 1;
    end
`else
    m = '0;
    k = 0;
`endif
  endfunction

  task automatic idle_inputs();
    bus.MdValid_ID = 1'b0;
    bus.flush      = 1'b0;
    bus.AnyStall   = 1'b0;
    bus.MdOp_ID    = 3'b000;
    bus.SrcA_ID    = '0;
    bus.SrcB_ID    = '0;
  endtask

  // Called just after a negedge; returns just after a negedge with the engine idle.
  task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string name);
    logic [31:0] ehi, elo;
    int          elat, n;
    ref_md(op, a, b, ehi, elo, elat);
    bus.MdValid_ID = 1'b1;
    bus.MdOp_ID    = op;
    bus.SrcA_ID    = a;
    bus.SrcB_ID    = b;
    @(negedge clk);
    bus.MdValid_ID = 1'b0;
    checks++;
    if (bus.MdBusy !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: busy=%b expected 1", name, bus.MdBusy);
    end
    n = 0;
    while (bus.MdBusy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== elat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, elat);
    end
    checks++;
    if (bus.Hi_MD !== ehi) begin
      errors++;
      $display("FAIL %s HI: got %h expected %h (a=%h b=%h)", name, bus.Hi_MD, ehi, a, b);
    end
    checks++;
    if (bus.Lo_MD !== elo) begin
      errors++;
      $display("FAIL %s LO: got %h expected %h (a=%h b=%h)", name, bus.Lo_MD, elo, a, b);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n          = 1'b0;
    bus.MdValid_ID = 1'b1;
    bus.MdOp_ID    = 3'b111;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.MdBusy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.MdBusy); end
    checks++;
    if (bus.MdStall_EXM1 !== 1'b0) begin errors++; $display("FAIL reset stall: got %b expected 0", bus.MdStall_EXM1); end
    checks++;
    if (bus.MdResult_EXM1 !== '0) begin errors++; $display("FAIL reset result: got %h expected 0", bus.MdResult_EXM1); end
    checks++;
    if (bus.Hi_MD !== '0 || bus.Lo_MD !== '0) begin
      errors++;
      $display("FAIL reset hilo: got %h/%h expected 0/0", bus.Hi_MD, bus.Lo_MD);
    end
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mt_mf();
    bus.MdValid_ID = 1'b1;
    bus.MdOp_ID    = 3'b100;
    bus.SrcA_ID    = 32'h0000_1234;
    #1;
    checks++;
    if (bus.MdStall_EXM1 !== 1'b0) begin errors++; $display("FAIL mthi stall: got %b expected 0", bus.MdStall_EXM1); end
    @(negedge clk);
    checks++;
    if (bus.Hi_MD !== 32'h0000_1234) begin errors++; $display("FAIL mthi hi: got %h expected 00001234", bus.Hi_MD); end
    bus.MdOp_ID = 3'b101;
    bus.SrcA_ID = 32'hCAFE_5678;
    @(negedge clk);
    checks++;
    if (bus.Lo_MD !== 32'hCAFE_5678) begin errors++; $display("FAIL mtlo lo: got %h expected cafe5678", bus.Lo_MD); end
    checks++;
    if (bus.MdBusy !== 1'b0) begin errors++; $display("FAIL mt busy: got %b expected 0", bus.MdBusy); end
    bus.MdOp_ID = 3'b110;
    #1;
    checks++;
    if (bus.MdResult_EXM1 !== 32'h0000_1234) begin errors++; $display("FAIL mfhi result: got %h expected 00001234", bus.MdResult_EXM1); end
    bus.MdOp_ID = 3'b111;
    #1;
    checks++;
    if (bus.MdResult_EXM1 !== 32'hCAFE_5678) begin errors++; $display("FAIL mflo result: got %h expected cafe5678", bus.MdResult_EXM1); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_directed();
    run_arith(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, "mult_7_m3");
    run_arith(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_arith(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
    run_arith(3'b011, 32'h0000_0009, 32'h0000_0000, "divu_by0");
    run_arith(3'b010, 32'hFFFF_FFF9, 32'h0000_0000, "div_neg_by0");
    run_arith(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_arith(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
    run_arith(3'b001, 32'h0000_0005, 32'h0000_0001, "multu_5_1");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ehi, elo, a, b;
    int          elat, n;
    run_arith(3'b001, 32'h0001_0000, 32'h0001_0000, "b2b_first");
    run_arith(3'b011, 32'd1000, 32'd7, "b2b_second");
    a = $urandom;
    b = $urandom;
    ref_md(3'b000, a, b, ehi, elo, elat);
    bus.MdValid_ID = 1'b1;
    bus.MdOp_ID    = 3'b000;
    bus.SrcA_ID    = a;
    bus.SrcB_ID    = b;
    @(negedge clk);
    bus.MdOp_ID = 3'b111;
    n = 0;
    while (bus.MdStall_EXM1 === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== elat) begin errors++; $display("FAIL mflo stall cycles: got %0d expected %0d", n, elat); end
    checks++;
    if (bus.MdResult_EXM1 !== elo) begin errors++; $display("FAIL mflo new lo: got %h expected %h", bus.MdResult_EXM1, elo); end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.Hi_MD !== ehi) begin errors++; $display("FAIL mflo hi kept: got %h expected %h", bus.Hi_MD, ehi); end
  endtask

  task automatic test_flush_anystall();
    logic [31:0] hi0, lo0;
    hi0 = bus.Hi_MD;
    lo0 = bus.Lo_MD;
    bus.MdValid_ID = 1'b1;
    bus.flush      = 1'b1;
    bus.MdOp_ID    = 3'b000;
    bus.SrcA_ID    = 32'd3;
    bus.SrcB_ID    = 32'd5;
    @(negedge clk);
    checks++;
    if (bus.MdBusy !== 1'b0) begin errors++; $display("FAIL flush mult busy: got %b expected 0", bus.MdBusy); end
    bus.flush    = 1'b0;
    bus.AnyStall = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.MdBusy !== 1'b0) begin errors++; $display("FAIL anystall mult busy: got %b expected 0", bus.MdBusy); end
    bus.MdOp_ID = 3'b100;
    bus.SrcA_ID = ~hi0;
    @(negedge clk);
    bus.AnyStall = 1'b0;
    bus.flush    = 1'b1;
    bus.MdOp_ID  = 3'b101;
    bus.SrcA_ID  = ~lo0;
    @(negedge clk);
    checks++;
    if (bus.Hi_MD !== hi0 || bus.Lo_MD !== lo0) begin
      errors++;
      $display("FAIL blocked mt hilo: got %h/%h expected %h/%h", bus.Hi_MD, bus.Lo_MD, hi0, lo0);
    end
    bus.MdOp_ID = 3'b111;
    #1;
    checks++;
    if (bus.MdResult_EXM1 !== '0) begin errors++; $display("FAIL flushed mflo result: got %h expected 0", bus.MdResult_EXM1); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    run_arith(3'b001, 32'h0012_3456, 32'h0000_0777, "pre_reset");
    bus.MdValid_ID = 1'b1;
    bus.MdOp_ID    = 3'b010;
    bus.SrcA_ID    = 32'd12345;
    bus.SrcB_ID    = 32'd17;
    @(negedge clk);
    idle_inputs();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.MdBusy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b expected 0", bus.MdBusy); end
    checks++;
    if (bus.Hi_MD !== '0 || bus.Lo_MD !== '0) begin
      errors++;
      $display("FAIL midreset hilo: got %h/%h expected 0/0", bus.Hi_MD, bus.Lo_MD);
    end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (bus.Hi_MD !== '0 || bus.Lo_MD !== '0) begin
      errors++;
      $display("FAIL midreset no late write: got %h/%h expected 0/0", bus.Hi_MD, bus.Lo_MD);
    end
    run_arith(3'b011, 32'd12345, 32'd17, "post_reset");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        3: b = 32'($urandom_range(0, 1023));
        default: ;
      endcase
      run_arith(op, a, b, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_mt_mf();
    test_directed();
    test_back_to_back();
    test_flush_anystall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
